pwm_decoder: RTL

PWM_DECODER -- requirements
Module: pwm_decoder

---
 rtl/pwm_pkg.sv | 28 ++
 rtl/pwm_sync_edge.sv | 54 +++++
 rtl/pwm_decoder.sv | 117 +++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared PWM constants, decoder state encoding and the duty rounding helper.
// Used by both the PWM generator and the decoder.
package pwm_pkg;

  localparam int PWM_PERIOD = 131072;
  localparam int PWM_SHIFT  = 9;
  localparam int PWM_TOL    = 4;
  localparam int CNT_W      = 18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pwm_state_e;

  // The generator emits code*2^shift + 1 high cycles.
  // Drop the extra cycle, round to nearest, clip to 8 bits.
  function automatic logic [7:0] duty_code(input logic [CNT_W-1:0] hi, input int shift);
    logic [CNT_W:0] round_c;
    logic [CNT_W:0] sum;
    logic [CNT_W:0] quo;
    round_c = (CNT_W+1)'(1) << (shift - 1);
    sum     = {1'b0, hi} + round_c - (CNT_W+1)'(1);
    quo     = sum >> shift;
    return (quo > (CNT_W+1)'(255)) ? 8'hFF : quo[7:0];
  endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer for the PWM input with registered rise/fall pulses.
// Edge detection is held off until the delayed copy holds post-reset data.
module pwm_sync_edge
  import pwm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [2:0] sr_reg;
  logic [1:0] warm_reg;
  logic       rise_reg;
  logic       fall_reg;
  logic       sync_v;
  logic       sync_d;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_stage
      always_ff @(posedge clk) begin
        if (rst)
          sr_reg[gi] <= 1'b0;
        else if (gi == 0)
          sr_reg[gi] <= din;
        else
          sr_reg[gi] <= sr_reg[gi-1];
      end
    end
  endgenerate

  assign sync_v = sr_reg[1];
  assign sync_d = sr_reg[2];

  // Without the warm-up gate a level already high at reset release looks like a rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      warm_reg <= 2'd0;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      if (warm_reg != 2'd3)
        warm_reg <= warm_reg + 2'd1;
      rise_reg <= (warm_reg == 2'd3) && sync_v && !sync_d;
      fall_reg <= (warm_reg == 2'd3) && !sync_v && sync_d;
    end
  end

  assign rise = rise_reg;
  assign fall = fall_reg;

endmodule

// File: rtl/pwm_decoder.sv
// PWM duty decoder: measures high time and frame length between rises,
// validates the frame length and reports an 8-bit duty code.
module pwm_decoder
  import pwm_pkg::*;
#(
  parameter int PERIOD = PWM_PERIOD,
  parameter int SHIFT  = PWM_SHIFT,
  parameter int TOL    = PWM_TOL
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwm_in,
  output logic [7:0] duty_out,
  output logic       duty_valid,
  output logic       locked,
  output logic       err
);

  localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(PERIOD - TOL);
  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(PERIOD + TOL);
  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(PERIOD + TOL + 1);

  logic rise;
  logic fall;

  pwm_state_e       state_reg, state_next;
  logic [CNT_W-1:0] hi_reg, hi_next;
  logic [CNT_W-1:0] per_reg, per_next;
  logic [7:0]       duty_reg, duty_next;
  logic             dv_reg, dv_next;
  logic             err_reg, err_next;
  logic             locked_reg, locked_next;

  pwm_sync_edge u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (pwm_in),
    .rise (rise),
    .fall (fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      hi_reg     <= '0;
      per_reg    <= '0;
      duty_reg   <= 8'h00;
      dv_reg     <= 1'b0;
      err_reg    <= 1'b0;
      locked_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      hi_reg     <= hi_next;
      per_reg    <= per_next;
      duty_reg   <= duty_next;
      dv_reg     <= dv_next;
      err_reg    <= err_next;
      locked_reg <= locked_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    hi_next     = hi_reg;
    per_next    = per_reg;
    duty_next   = duty_reg;
    dv_next     = 1'b0;
    err_next    = 1'b0;
    locked_next = locked_reg;
    case (state_reg)
      IDLE: begin
        if (rise) begin
          state_next = HIGH;
          hi_next    = CNT_W'(1);
          per_next   = CNT_W'(1);
        end
      end
      HIGH, LOW: begin
        if (state_reg == LOW && rise) begin
          if (per_reg >= MIN_LEN && per_reg <= MAX_LEN) begin
            duty_next   = duty_code(hi_reg, SHIFT);
            dv_next     = 1'b1;
            locked_next = 1'b1;
          end else begin
            err_next    = 1'b1;
            locked_next = 1'b0;
          end
          // The closing rise opens the next frame immediately.
          state_next = HIGH;
          hi_next    = CNT_W'(1);
          per_next   = CNT_W'(1);
        end else if (per_reg == TIMEOUT) begin
          err_next    = 1'b1;
          locked_next = 1'b0;
          state_next  = IDLE;
          hi_next     = '0;
          per_next    = '0;
        end else begin
          per_next = per_reg + 1'b1;
          if (state_reg == HIGH) begin
            if (fall)
              state_next = LOW;
            else
              hi_next = hi_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign duty_out   = duty_reg;
  assign duty_valid = dv_reg;
  assign err        = err_reg;
  assign locked     = locked_reg;

endmodule
